// File: rtl/booth_mul_sequencer.sv
// Signed radix-4 Booth multiplier that retires one Booth digit per clock.
// Latency: done pulses BITS/2 edges after the start-accept edge; busy is high for BITS/2 cycles.
// Backpressure: start is honoured only in IDLE or DONE, and is ignored while busy.
module booth_mul_sequencer #(
  parameter int BITS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [BITS-1:0]   multiplicand,
  input  logic [BITS-1:0]   multiplier,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] product,
  output logic [BITS-1:0]   hi,
  output logic [BITS-1:0]   lo
);

  localparam int STEPS = BITS / 2;
  localparam int STEPW = $clog2(STEPS) + 1;
  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [BITS-1:0]   r_m;
  logic [BITS-1:0]   r_q;
  logic [2*BITS-1:0] r_acc;
  logic [STEPW-1:0]  r_step;
  logic [2*BITS-1:0] r_product;

  // Q with an implicit zero below bit 0, so digit j is the 3-bit window starting at bit 2j.
  logic [BITS:0]     w_qx;
  logic [STEPW:0]    w_shamt;
  logic [2:0]        w_digit;
  logic [2*BITS-1:0] w_mext;
  logic [2*BITS-1:0] w_pp;
  logic [2*BITS-1:0] w_acc_next;

  assign w_qx    = {r_q, 1'b0};
  assign w_shamt = {r_step, 1'b0};
  assign w_digit = 3'(w_qx >> w_shamt);
  // Sign-extend before doubling/negating so M = -2^(BITS-1) stays exact.
  assign w_mext  = {{BITS{r_m[BITS-1]}}, r_m};

  // Booth digit to partial product selection.
  always_comb begin
    w_pp = '0;
    case (w_digit)
      3'b001, 3'b010: w_pp = w_mext;
      3'b011:         w_pp = w_mext << 1;
      3'b100:         w_pp = -(w_mext << 1);
      3'b101, 3'b110: w_pp = -w_mext;
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_next = r_acc + (w_pp << w_shamt);

  // Sequencer: operand capture, one Booth step per cycle, result commit on the last step.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_step    <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_acc   <= '0;
            r_step  <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + 1'b1;
          if (r_step == LAST_STEP) begin
            r_product <= w_acc_next;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
  assign hi      = r_product[2*BITS-1:BITS];
  assign lo      = r_product[BITS-1:0];

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed and random checks of booth_mul_sequencer at BITS=32.
// Drives inputs and samples outputs on the falling clock edge.
// Each operation is bounded by a cycle budget so the run always ends.
module tb_booth_mul_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic signed [63:0] sa, sb;
  logic [31:0]        rm, rq;
  int                 n;

  booth_mul_sequencer #(.BITS(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete operation; poke>0 pulses start with 100x100 in that busy cycle.
  task automatic do_op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp,
                       input int poke, input string tag);
    logic [63:0] prev;
    int          cnt;
    bit          held;
    @(negedge clock);
    start = 1'b1; multiplicand = m; multiplier = q;
    prev = product;
    @(negedge clock);
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    cnt = 0; held = 1'b1;
    while (busy && !done && cnt < 40) begin
      cnt++;
      if (product !== prev) held = 1'b0;
      if (cnt == poke) begin
        start = 1'b1; multiplicand = 32'd100; multiplier = 32'd100;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    chk({tag, " busy_cycles"}, 64'(cnt), 64'd16);
    chk({tag, " held"}, 64'(held), 64'd1);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, " product"}, product, exp);
    chk({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clock);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", product, 64'd0);
    reset = 1'b0;

    // Basic case, then DONE must fall to IDLE when start is low.
    do_op(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0, "7x-3");
    @(negedge clock);
    chk("7x-3 done_falls", 64'(done), 64'd0);
    chk("7x-3 idle_busy", 64'(busy), 64'd0);
    chk("7x-3 product_kept", product, 64'hFFFF_FFFF_FFFF_FFEB);

    // Extremes.
    do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, "min_x_min");
    do_op(32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 0, "min_x_1");
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 0, "max_x_max");

    // start pulse at RUN step 5 (sixth busy cycle) is ignored.
    do_op(32'd1234, 32'hFFFF_E9D2, 64'hFFFF_FFFF_FF95_1644, 6, "start_in_run");

    // Back-to-back: start held high, new operands presented in the done cycle.
    @(negedge clock);
    start = 1'b1; multiplicand = 32'd5; multiplier = 32'd6;
    @(negedge clock);
    multiplicand = 32'd100; multiplier = 32'd100;
    n = 0;
    while (!done && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("b2b first_latency", 64'(n), 64'd16);
    chk("b2b first_product", product, 64'h1E);
    multiplicand = 32'hFFFF_FFFF; multiplier = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("b2b no_idle_busy", 64'(busy), 64'd1);
    chk("b2b no_idle_done", 64'(done), 64'd0);
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    n = 0;
    while (!done && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("b2b second_latency", 64'(n), 64'd16);
    chk("b2b second_product", product, 64'h1);

    // Reset at RUN step 8 aborts the operation.
    @(negedge clock);
    start = 1'b1; multiplicand = 32'd7; multiplier = 32'hFFFF_FFFD;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort product", product, 64'd0);
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) n++;
    end
    chk("abort no_done", 64'(n), 64'd0);
    do_op(32'd3, 32'd4, 64'd12, 0, "after_abort");

    // Random signed pairs against a 64-bit signed reference multiply.
    for (int i = 0; i < 1000; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i % 10 == 0) rm = '0;
      if (i % 10 == 1) rq = '1;
      if (i % 10 == 2) begin rm = '1; rq = '1; end
      if (i % 10 == 3) rq = '0;
      sa = $signed(rm);
      sb = $signed(rq);
      do_op(rm, rq, 64'(sa * sb), 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mul_sequencer.md
Name: booth_mul_sequencer

Overview:
Multi-cycle signed multiply unit built around radix-4 Booth recoding. It retires one Booth digit per clock instead of summing all partial products combinationally. It sits beside the ALU, and the control unit launches it with a start/busy/done handshake. The 2·BITS-bit result is delivered as a full product plus HI/LO halves for the HI and LO registers.

Parameters:
BITS, 32, operand width; must be even and >= 4; number of Booth steps = BITS/2

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  launch request; sampled only in IDLE or DONE
multiplicand  in  BITS  signed two's-complement operand M; sampled on accepted start
multiplier  in  BITS  signed two's-complement operand Q; sampled on accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; result registers are valid and newly updated
product  out  2*BITS  signed product M*Q, held until the next completion
hi  out  BITS  product[2*BITS-1:BITS]
lo  out  BITS  product[BITS-1:0]

Behaviour:
- Registered state: FSM state, latched M and Q, accumulator acc (2*BITS), step counter (log2(BITS/2)+1 bits), product register.
- Reset (synchronous, has priority over everything): state=IDLE, busy=0, done=0, product=0, acc=0, step=0. Reset during RUN aborts the operation; no done pulse is issued and product reads 0.
- Operand capture: on a rising edge in IDLE or DONE with start=1, latch M and Q, then set acc=0, step=0, state=RUN.
- RUN step j, for j = 0..BITS/2-1, on each edge:
  - form the digit g = {Q[2j+1], Q[2j], Q[2j-1]}, with Q[-1]=0;
  - select the partial product: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M;
  - compute the partial product sign-extended to full 2*BITS width before negation and doubling, so that M = -2^(BITS-1) negates correctly;
  - add it to acc shifted left 2j, modulo 2^(2*BITS);
  - increment step.
- End of RUN: on the edge performing step BITS/2-1, write acc-plus-final-term directly into product, set done=1, busy=0, state=DONE.
- Latency: done rises on the BITS/2-th edge after the start-accept edge (16 for BITS=32). busy is high for exactly BITS/2 cycles.
- DONE lasts exactly one cycle:
  - with start=0, go to IDLE and set done=0;
  - with start=1, accept new operands and go straight to RUN (back-to-back, zero idle cycles).
- start during RUN is ignored. Operands are not re-sampled, and the in-flight result is unaffected.
- Operand inputs may change freely after the accept edge, because only the latched copies are used.
- product, hi and lo change only on the completion edge (or on reset). Their values are stable between completions.
- Result range: every signed product fits in 2*BITS bits, including (-2^(BITS-1))^2 = 2^(2*BITS-2). No overflow flag is provided.
- done and busy are never high in the same cycle.

Test Plan:
- 7 x -3 (BITS=32): start for 1 cycle -> busy high 16 cycles, then done pulse; product = 0xFFFFFFFF_FFFFFFEB, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- Extremes: 0x80000000 x 0x80000000 -> 0x40000000_00000000; 0x80000000 x 0x00000001 -> 0xFFFFFFFF_80000000; 0x7FFFFFFF x 0x7FFFFFFF -> 0x3FFFFFFF_00000001.
- Back-to-back: hold start high with 5 x 6 and change the operands to -1 x -1 in the done cycle -> first done gives 0x1E, second done (16 cycles later) gives 0x1; no IDLE cycle in between.
- Start while busy: pulse start with 100 x 100 at RUN step 5 -> ignored; original result delivered at the original time; product unchanged otherwise.
- Reset mid-op: assert reset at RUN step 8 -> next cycle busy=0, done=0, product=0; no done pulse follows; a fresh start then completes normally.
- Random: 1000 signed random pairs checked against a reference 64-bit signed multiply, including zero and all-ones operands; check done spacing and that product holds between completions.
